// File: rtl/clm_sub_bytes_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clm_sub_bytes_sched_pkg
// Purpose  : Shared types, constants and helpers for the CLM SubBytes
//            scheduler and its lane multiplexer.
// Contents : red_poly_t    - one redundant state element (8+D bits)
//            state_vec_t   - the 16 state elements, byte b at [b*W +: W]
//            rnd_vec_t     - NUM_R randomness words, word i at [i*W +: W]
//            sched_state_e - scheduler FSM states
//            rotate_r()    - rotate a randomness vector by a word count
// Revision : 1.0 - initial release
// ============================================================================
package clm_sub_bytes_sched_pkg;

  localparam int CLM_D     = 4;
  localparam int CLM_W     = 8 + CLM_D;
  localparam int CLM_NUM_R = 7;
  localparam int NUM_BYTES = 16;

  typedef logic [CLM_W-1:0]               red_poly_t;
  typedef logic [NUM_BYTES*CLM_W-1:0]     state_vec_t;
  typedef logic [CLM_NUM_R*CLM_W-1:0]     rnd_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  // Word i of the result is word (i + shamt) mod NUM_R of the input.
  function automatic rnd_vec_t rotate_r(input rnd_vec_t vec, input logic [3:0] shamt);
    rnd_vec_t res;
    res = '0;
    for (int i = 0; i < CLM_NUM_R; i++) begin
      res[i*CLM_W +: CLM_W] = vec[((i + int'(shamt)) % CLM_NUM_R)*CLM_W +: CLM_W];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clm_sub_bytes_sched_lane_mux.sv
`default_nettype none
// ============================================================================
// Module   : clm_lane_mux
// Purpose  : Combinational byte/randomness selection for the shared S-box
//            lanes. Lane k serves byte b = batch*NUM_SBOX + k and receives the
//            latched randomness rotated by (b mod NUM_R). Also flags which
//            lanes capture a result this cycle and the matching byte enables.
// Ports    : batch_i     - current batch index
//            wait_i      - scheduler is in WAIT (captures allowed)
//            state_i     - latched input state
//            r_i         - latched randomness
//            lane_done_i - lanes already captured in this batch
//            drdy_i      - lane result-valid
//            sb_in_o     - per-lane input element
//            sb_r_o      - per-lane rotated randomness
//            lane_cap_o  - lane captures its result this cycle
//            wr_en_o     - per-byte out_state write enable
// Revision : 1.0 - initial release
// ============================================================================
module clm_lane_mux
  import clm_sub_bytes_sched_pkg::*;
#(
  parameter int NUM_SBOX = 4,
  parameter int BATCH_W  = 2
) (
  input  logic [BATCH_W-1:0]                   batch_i,
  input  logic                                 wait_i,
  input  state_vec_t                           state_i,
  input  rnd_vec_t                             r_i,
  input  logic [NUM_SBOX-1:0]                  lane_done_i,
  input  logic [NUM_SBOX-1:0]                  drdy_i,
  output logic [NUM_SBOX*CLM_W-1:0]            sb_in_o,
  output logic [NUM_SBOX*CLM_NUM_R*CLM_W-1:0]  sb_r_o,
  output logic [NUM_SBOX-1:0]                  lane_cap_o,
  output logic [NUM_BYTES-1:0]                 wr_en_o
);

  localparam int RW = CLM_NUM_R * CLM_W;

  for (genvar k = 0; k < NUM_SBOX; k++) begin : g_lane
    logic [3:0] byte_idx;
    // Truncation to 4 bits is exact: batch*NUM_SBOX + k never exceeds 15.
    assign byte_idx = 4'(int'(batch_i) * NUM_SBOX + k);
    assign sb_in_o[k*CLM_W +: CLM_W] = state_i[int'(byte_idx)*CLM_W +: CLM_W];
    // Rotation keyed on the byte index keeps results independent of NUM_SBOX.
    assign sb_r_o[k*RW +: RW] = rotate_r(r_i, 4'(int'(byte_idx) % CLM_NUM_R));
    // Repeat drdy after capture is ignored so a late pulse cannot overwrite.
    assign lane_cap_o[k] = wait_i & drdy_i[k] & ~lane_done_i[k];
  end

  for (genvar b = 0; b < NUM_BYTES; b++) begin : g_wr
    localparam int LANE  = b % NUM_SBOX;
    localparam int BATCH = b / NUM_SBOX;
    assign wr_en_o[b] = lane_cap_o[LANE] && (int'(batch_i) == BATCH);
  end

endmodule
`default_nettype wire

// File: rtl/clm_sub_bytes_sched.sv
`default_nettype none
// ============================================================================
// Module   : clm_sub_bytes_sched
// Purpose  : SubBytes stage of the CLM AES core. Time-multiplexes NUM_SBOX
//            external masked S-box lanes over the 16 state bytes in batches,
//            collects per-lane results with independent completion and
//            raises a one-cycle done strobe.
// Ports    : clk, rst_n    - clock, asynchronous active-low reset
//            start_i       - begin a run (accepted only in IDLE)
//            abort_i       - return to IDLE without done
//            in_state_i    - input state, byte b = 4*row+col
//            r_i           - randomness words for this run
//            out_state_o   - substituted state
//            done_o        - one-cycle completion strobe
//            busy_o        - not IDLE
//            sb_start_o    - per-lane start strobe
//            sb_in_o       - per-lane input element
//            sb_r_o        - per-lane randomness
//            sb_drdy_i     - per-lane result valid
//            sb_out_i      - per-lane result
// Revision : 1.0 - initial release
// ============================================================================
module clm_sub_bytes_sched
  import clm_sub_bytes_sched_pkg::*;
#(
  parameter  int D        = CLM_D,
  parameter  int NUM_SBOX = 4,
  parameter  int NUM_R    = CLM_NUM_R,
  localparam int W        = 8 + D
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic [16*W-1:0]             in_state_i,
  input  logic [NUM_R*W-1:0]          r_i,
  output logic [16*W-1:0]             out_state_o,
  output logic                        done_o,
  output logic                        busy_o,
  output logic [NUM_SBOX-1:0]         sb_start_o,
  output logic [NUM_SBOX*W-1:0]       sb_in_o,
  output logic [NUM_SBOX*NUM_R*W-1:0] sb_r_o,
  input  logic [NUM_SBOX-1:0]         sb_drdy_i,
  input  logic [NUM_SBOX*W-1:0]       sb_out_i
);

  localparam int NUM_BATCH = 16 / NUM_SBOX;
  localparam int BATCH_W   = (NUM_BATCH > 1) ? $clog2(NUM_BATCH) : 1;
  localparam logic [BATCH_W-1:0] LAST_BATCH = BATCH_W'(NUM_BATCH - 1);

  if ((NUM_SBOX < 1) || (16 % NUM_SBOX != 0)) begin : g_bad_num_sbox
    $error("clm_sub_bytes_sched: NUM_SBOX must divide 16");
  end
  // The element and randomness types are shared core-wide through the package.
  if ((D != CLM_D) || (NUM_R != CLM_NUM_R)) begin : g_bad_width
    $error("clm_sub_bytes_sched: D/NUM_R must match clm_sub_bytes_sched_pkg");
  end

  sched_state_e          state_q, state_d;
  logic [BATCH_W-1:0]    batch_q, batch_d;
  logic [NUM_SBOX-1:0]   lane_done_q, lane_done_d;
  state_vec_t            in_state_q, in_state_d;
  rnd_vec_t              r_q, r_d;
  state_vec_t            out_state_q, out_state_d;

  logic [NUM_SBOX-1:0]   lane_cap;
  logic [NUM_BYTES-1:0]  wr_en;

  clm_lane_mux #(
    .NUM_SBOX (NUM_SBOX),
    .BATCH_W  (BATCH_W)
  ) u_lane_mux (
    .batch_i     (batch_q),
    .wait_i      (state_q == WAIT),
    .state_i     (in_state_q),
    .r_i         (r_q),
    .lane_done_i (lane_done_q),
    .drdy_i      (sb_drdy_i),
    .sb_in_o     (sb_in_o),
    .sb_r_o      (sb_r_o),
    .lane_cap_o  (lane_cap),
    .wr_en_o     (wr_en)
  );

  always_comb begin
    state_d     = state_q;
    batch_d     = batch_q;
    lane_done_d = lane_done_q;
    in_state_d  = in_state_q;
    r_d         = r_q;
    out_state_d = out_state_q;

    for (int b = 0; b < NUM_BYTES; b++) begin
      if (wr_en[b]) begin
        out_state_d[b*W +: W] = sb_out_i[(b % NUM_SBOX)*W +: W];
      end
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          in_state_d  = in_state_i;
          r_d         = r_i;
          lane_done_d = '0;
          batch_d     = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        lane_done_d = lane_done_q | lane_cap;
        // Lanes captured this cycle count toward batch completion.
        if (&lane_done_d) begin
          if (batch_q == LAST_BATCH) begin
            state_d = DONE;
          end else begin
            batch_d     = batch_q + BATCH_W'(1);
            lane_done_d = '0;
            state_d     = ISSUE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_i) begin
      state_d     = IDLE;
      lane_done_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      batch_q     <= '0;
      lane_done_q <= '0;
      in_state_q  <= '0;
      r_q         <= '0;
      out_state_q <= '0;
    end else begin
      state_q     <= state_d;
      batch_q     <= batch_d;
      lane_done_q <= lane_done_d;
      in_state_q  <= in_state_d;
      r_q         <= r_d;
      out_state_q <= out_state_d;
    end
  end

  assign out_state_o = out_state_q;
  assign done_o      = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign sb_start_o  = {NUM_SBOX{state_q == ISSUE}};

endmodule
`default_nettype wire
